// File: rtl/counter_compare_pwm.sv
// Compare/PWM stage behind the free-running counter: two double-buffered
// compare channels producing PWM, match pulses, sticky flags and a wrap pulse.
module counter_compare_pwm #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] count,
  input  logic             cmp_wr,
  input  logic             cmp_sel,
  input  logic [WIDTH-1:0] cmp_data,
  input  logic [1:0]       irq_clr,
  output logic [1:0]       pwm,
  output logic [1:0]       match_pulse,
  output logic [1:0]       irq_flag,
  output logic             wrap_pulse,
  output logic [1:0]       pending
);

  logic [WIDTH-1:0] shadow [2];
  logic [WIDTH-1:0] active [2];
  logic             wrap;
  logic [1:0]       wr_hit;
  logic [1:0]       hit;
  logic [1:0]       below;

  // cmp_wr is a single-cycle strobe with no back-pressure: every edge with
  // cmp_wr = 1 is one accepted write into shadow[cmp_sel].
  always_comb begin
    wrap   = (count == '1) && enable;
    wr_hit = '0;
    hit    = '0;
    below  = '0;
    for (int ch = 0; ch < 2; ch++) begin
      wr_hit[ch] = cmp_wr && (cmp_sel == 1'(ch));
      hit[ch]    = (count == active[ch]) && enable;
      below[ch]  = count < active[ch];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int ch = 0; ch < 2; ch++) begin
        shadow[ch] <= '0;
        active[ch] <= '0;
      end
      pwm         <= '0;
      match_pulse <= '0;
      irq_flag    <= '0;
      wrap_pulse  <= 1'b0;
      pending     <= '0;
    end else begin
      wrap_pulse  <= wrap;
      pwm         <= below;
      match_pulse <= hit;
      // a set on the same edge as a clear wins
      irq_flag    <= hit | (irq_flag & ~irq_clr);
      for (int ch = 0; ch < 2; ch++) begin
        // transfer reads the shadow before this edge's write lands
        if (wrap && pending[ch]) active[ch] <= shadow[ch];
        if (wr_hit[ch]) begin
          shadow[ch]  <= cmp_data;
          pending[ch] <= 1'b1;
        end else if (wrap) begin
          pending[ch] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_counter_compare_pwm.sv
// Directed bench for counter_compare_pwm; the bench plays the counter stage
// and tallies PWM/match/wrap activity over whole periods.
module tb_counter_compare_pwm;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [7:0] count;
  logic       cmp_wr;
  logic       cmp_sel;
  logic [7:0] cmp_data;
  logic [1:0] irq_clr;
  logic [1:0] pwm;
  logic [1:0] match_pulse;
  logic [1:0] irq_flag;
  logic       wrap_pulse;
  logic [1:0] pending;

  int checks = 0;
  int errors = 0;

  int pwm_hi [2];
  int pwm_lo_at [2];
  int match_cnt [2];
  int match_at [2];
  int wrap_cnt;

  counter_compare_pwm #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .count(count),
    .cmp_wr(cmp_wr), .cmp_sel(cmp_sel), .cmp_data(cmp_data), .irq_clr(irq_clr),
    .pwm(pwm), .match_pulse(match_pulse), .irq_flag(irq_flag),
    .wrap_pulse(wrap_pulse), .pending(pending)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic clear_tally();
    for (int ch = 0; ch < 2; ch++) begin
      pwm_hi[ch] = 0; pwm_lo_at[ch] = -1; match_cnt[ch] = 0; match_at[ch] = -1;
    end
    wrap_cnt = 0;
  endtask

  // one clock edge; the bench's counter advances on enabled edges
  task automatic tick();
    logic [7:0] prev;
    prev = count;
    @(posedge clk);
    #1;
    cmp_wr  = 1'b0;
    irq_clr = 2'b00;
    if (enable) count = count + 8'd1;
    for (int ch = 0; ch < 2; ch++) begin
      if (pwm[ch]) pwm_hi[ch]++;
      else pwm_lo_at[ch] = int'(prev);
      if (match_pulse[ch]) begin
        match_cnt[ch]++;
        match_at[ch] = int'(prev);
      end
    end
    if (wrap_pulse) wrap_cnt++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_to(input logic [7:0] v);
    int n;
    n = 0;
    while (count != v && n < 600) begin
      tick();
      n++;
    end
    if (count != v) check("run_to_bound", 32'(count), 32'(v));
  endtask

  task automatic write_cmp(input logic sel, input logic [7:0] data);
    cmp_wr = 1'b1; cmp_sel = sel; cmp_data = data;
    tick();
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; count = 8'd0;
    cmp_wr = 1'b0; cmp_sel = 1'b0; cmp_data = 8'd0; irq_clr = 2'b00;
    clear_tally();
    ticks(3);
    check("reset_outputs", 32'({pwm, match_pulse, irq_flag, wrap_pulse, pending}), 32'd0);
    reset = 1'b1;
    enable = 1'b1;

    // shadow transfer
    run_to(8'd10);
    clear_tally();
    write_cmp(1'b0, 8'd64);
    check("xfer_pending_set", 32'(pending), 32'd1);
    run_to(8'd255);
    check("xfer_pending_hold", 32'(pending), 32'd1);
    check("xfer_pwm_before", 32'(pwm_hi[0]), 32'd0);
    check("xfer_no_early_wrap", 32'(wrap_cnt), 32'd0);
    tick();
    check("xfer_wrap_pulse", 32'(wrap_pulse), 32'd1);
    check("xfer_pending_clr", 32'(pending), 32'd0);
    clear_tally();
    ticks(256);
    check("xfer_duty64", 32'(pwm_hi[0]), 32'd64);
    check("xfer_match_at", 32'(match_at[0]), 32'd64);
    check("xfer_wraps", 32'(wrap_cnt), 32'd1);

    // boundary duties 0 and 255
    write_cmp(1'b0, 8'd0);
    write_cmp(1'b1, 8'd255);
    run_to(8'd255);
    tick();
    clear_tally();
    ticks(256);
    check("bnd_pwm0_high", 32'(pwm_hi[0]), 32'd0);
    check("bnd_pwm1_high", 32'(pwm_hi[1]), 32'd255);
    check("bnd_pwm1_low_at", 32'(pwm_lo_at[1]), 32'd255);
    check("bnd_match0_cnt", 32'(match_cnt[0]), 32'd1);
    check("bnd_match0_at", 32'(match_at[0]), 32'd0);
    check("bnd_match1_cnt", 32'(match_cnt[1]), 32'd1);
    check("bnd_match1_at", 32'(match_at[1]), 32'd255);

    // pause at a match
    write_cmp(1'b0, 8'd200);
    write_cmp(1'b1, 8'd100);
    run_to(8'd255);
    tick();
    run_to(8'd50);
    irq_clr = 2'b11;
    tick();
    check("pause_flags_clr", 32'(irq_flag), 32'd0);
    run_to(8'd100);
    clear_tally();
    tick();
    check("pause_match", 32'(match_pulse), 32'd2);
    count = 8'd100;
    enable = 1'b0;
    ticks(20);
    check("pause_match_once", 32'(match_cnt[1]), 32'd1);
    check("pause_pwm1_low", 32'(pwm_hi[1]), 32'd0);
    check("pause_flag1", 32'(irq_flag), 32'd2);
    enable = 1'b1;
    count = 8'd101;

    // write collides with wrap
    write_cmp(1'b0, 8'd32);
    run_to(8'd255);
    cmp_wr = 1'b1; cmp_sel = 1'b0; cmp_data = 8'd200;
    tick();
    check("coll_wrap", 32'(wrap_pulse), 32'd1);
    check("coll_pending", 32'(pending), 32'd1);
    clear_tally();
    ticks(256);
    check("coll_duty32", 32'(pwm_hi[0]), 32'd32);
    check("coll_match_at", 32'(match_at[0]), 32'd32);
    check("coll_ch1_duty", 32'(pwm_hi[1]), 32'd100);
    check("coll_pending_clr", 32'(pending), 32'd0);
    clear_tally();
    ticks(256);
    check("coll_duty200", 32'(pwm_hi[0]), 32'd200);

    // flag race: set beats clear
    run_to(8'd150);
    irq_clr = 2'b01;
    tick();
    check("race_pre_flags", 32'(irq_flag), 32'd2);
    run_to(8'd200);
    irq_clr = 2'b01;
    tick();
    check("race_set_wins", 32'(irq_flag), 32'd3);
    check("race_match0", 32'(match_pulse), 32'd1);
    irq_clr = 2'b01;
    tick();
    check("race_clear", 32'(irq_flag), 32'd2);

    // wrap qualification
    run_to(8'd255);
    enable = 1'b0;
    tick();
    check("wrap_needs_enable", 32'(wrap_pulse), 32'd0);
    enable = 1'b1;
    tick();
    check("wrap_enabled", 32'(wrap_pulse), 32'd1);
    run_to(8'd100);
    count = 8'd0;
    clear_tally();
    ticks(3);
    check("sync_reset_no_wrap", 32'(wrap_cnt), 32'd0);

    // asynchronous reset mid-run
    run_to(8'd255);
    tick();
    run_to(8'd10);
    check("arst_pre_pwm", 32'(pwm), 32'd3);
    check("arst_pre_flags", 32'(irq_flag), 32'd3);
    #2;
    reset = 1'b0;
    #1;
    check("arst_immediate", 32'({pwm, match_pulse, irq_flag, wrap_pulse, pending}), 32'd0);
    ticks(2);
    reset = 1'b1;
    clear_tally();
    ticks(300);
    check("arst_pwm0_idle", 32'(pwm_hi[0]), 32'd0);
    check("arst_pwm1_idle", 32'(pwm_hi[1]), 32'd0);
    check("arst_pending", 32'(pending), 32'd0);
    check("arst_wraps", 32'(wrap_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_compare_pwm.md
Name: counter_compare_pwm

Overview:
- Downstream consumer of the 8-bit free-running counter stage: samples its count value and count-enable.
- Produces two PWM outputs, per-channel compare-match pulses, sticky interrupt flags and a wrap (period) pulse.
- Compare values are double-buffered: software writes a shadow register, which transfers to the active register at counter wrap, so PWM periods are always glitch-free.

Parameters:
WIDTH, 8, width of the counter value and compare registers

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous active-low reset (0 = reset asserted)
enable  input  1  count-advance qualifier; same signal that drives the counter stage's enable
count  input  WIDTH  registered counter value from the counter stage
cmp_wr  input  1  write strobe for a shadow compare register
cmp_sel  input  1  shadow register select (0 = channel 0, 1 = channel 1)
cmp_data  input  WIDTH  shadow compare write data
irq_clr  input  2  per-channel sticky flag clear, one bit per channel
pwm  output  2  registered PWM outputs
match_pulse  output  2  one-cycle compare-match pulses
irq_flag  output  2  sticky match flags
wrap_pulse  output  1  one-cycle pulse marking the start of a new period
pending  output  2  shadow value written but not yet transferred to active

Behaviour:
- Reset (reset = 0, asynchronous): all of the following clear to 0: shadow[1:0], active[1:0], pwm, match_pulse, irq_flag, wrap_pulse, pending.
- Release is synchronous to clk.
- Wrap condition W: count == all-ones AND enable == 1, sampled at a rising edge. W means the counter shows 0 on the next cycle.
- wrap_pulse: registered W. It is high during exactly the first cycle in which count == 0 after a wrap.
- Counter-stage synchronous reset (count forced to 0 without passing through all-ones) does not produce wrap_pulse.
- Shadow write: on an edge with cmp_wr = 1:
  - shadow[cmp_sel] <= cmp_data
  - pending[cmp_sel] <= 1
- Transfer: on an edge with W = 1, for each channel with pending = 1:
  - active <= shadow
  - pending <= 0
- Channels with pending = 0 keep their active value.
- Simultaneous cmp_wr and W on the same channel:
  - active takes the OLD shadow value.
  - shadow takes cmp_data.
  - pending stays 1.
- Repeated writes before a wrap: the last write wins; only one transfer occurs.
- PWM: pwm[ch] <= (count < active[ch]), unsigned compare, evaluated every edge regardless of enable. Latency is 1 cycle from count.
  - active = 0: pwm constantly 0.
  - active = 255: pwm is 0 only for the cycle after count = 255.
  - Duty = active / 256.
- Match: match_pulse[ch] <= (count == active[ch]) AND enable.
  - While enable = 0 (paused), no repeated pulses are generated.
  - active = 0 matches at count 0 when enable = 1.
- Sticky flags, per channel:
  - The flag sets on the same edge that match_pulse is asserted.
  - irq_clr = 1 clears it.
  - Simultaneous set and clear: set wins (flag stays 1).
- Transfer and compare on the same edge: match and pwm use the active value from before the edge. The new value affects the next cycle onward.
- No combinational path from any input to any output.

Test Plan:
- Reset mid-run: drive reset = 0 while pwm = 2'b11 and irq_flag = 2'b11 -> all outputs 0 immediately, without waiting for clk; after release pwm stays 0 until a transfer occurs.
- Shadow transfer: write ch0 = 64 at count = 10 -> pending[0] = 1; active is unchanged until the edge with count = 255 and enable = 1; then wrap_pulse = 1 with count = 0 and pending[0] = 0; in the next period pwm[0] is high for exactly 64 cycles.
- Boundary duties: ch0 = 0, ch1 = 255, run one full period -> pwm[0] is never high; pwm[1] is low for exactly 1 cycle (the cycle after count = 255); match_pulse[0] fires at count 0 and match_pulse[1] at count 255.
- Pause: ch1 = 100, drop enable while count = 100 for 20 cycles -> match_pulse[1] is high for one cycle only, irq_flag[1] = 1, and pwm[1] is held at 0.
- Write collides with wrap: shadow0 = 32 pending; write ch0 = 200 on the W edge -> active0 = 32, shadow0 = 200, pending[0] = 1; at the next wrap active0 = 200.
- Flag race: assert irq_clr[0] on the same edge as a ch0 match -> irq_flag[0] = 1; assert irq_clr[0] one cycle later -> irq_flag[0] = 0.
